// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port plus
// the valid/ready output stream toward decode.
interface instruction_fetch_if #(
  parameter int n = 16
);
  logic [2*n-1:0] imem_addr;
  logic           imem_en;
  logic [2*n-1:0] imem_data;
  logic           out_valid;
  logic [2*n-1:0] out_instr;
  logic [2*n-1:0] out_pc;
  logic           out_ready;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_data,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_data,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, redirect handling
// and a two-entry {pc, instr} queue toward decode.
module instruction_fetch #(
  parameter int             n        = 16,
  parameter logic [2*n-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           halt,
  input  logic           redirect_valid,
  input  logic [2*n-1:0] redirect_pc,
  output logic           fault,
  output logic           busy,
  instruction_fetch_if.master bus
);

  localparam int W = 2 * n;

  // first byte address past the memory, held wide enough not to wrap
  localparam logic [W+2:0] LIMIT =
    {{W{1'b0}}, 3'b100} << n;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_pc;
  logic [W-1:0]   w_pc_nxt;

  logic [W-1:0]   r_q_pc    [2];
  logic [W-1:0]   r_q_instr [2];
  logic           r_head;
  logic [1:0]     r_count;

  logic           w_valid;
  logic           w_full;
  logic           w_pop;
  logic           w_fetch;
  logic           w_in_range;
  logic           w_redir;
  logic           w_misalign;
  logic           w_tail;

  always_comb begin
    w_valid    = (r_count != 2'd0);
    w_full     = (r_count == 2'd2);
    w_pop      = w_valid && bus.out_ready;
    w_in_range = ({3'b000, r_pc} < LIMIT);
    w_redir    = redirect_valid
               && (r_state != S_FAULT);
    w_misalign = (redirect_pc[1:0] != 2'b00);
    w_tail     = r_head ^ r_count[0];
    w_fetch    = (r_state == S_RUN)
               && !halt
               && !redirect_valid
               && w_in_range
               && (!w_full || w_pop);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_redir && w_misalign) begin
      w_state_nxt = S_FAULT;
    end else if (w_redir) begin
      if ((r_state == S_RUN) && halt)
        w_state_nxt = S_HALTED;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && halt)
            w_state_nxt = S_HALTED;
          else if (start)
            w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (!w_in_range)
            w_state_nxt = S_FAULT;
          else if (halt)
            w_state_nxt = S_HALTED;
        end
        S_HALTED: begin
          if (start && !halt)
            w_state_nxt = S_RUN;
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
      endcase
    end
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redir && !w_misalign)
      w_pc_nxt = redirect_pc;
    else if (w_fetch)
      w_pc_nxt = r_pc + W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // a full queue can push and pop together: the tail slot is the head
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else if (w_redir) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_fetch) begin
        r_q_pc[w_tail]    <= r_pc;
        r_q_instr[w_tail] <= bus.imem_data;
      end
      r_head  <= r_head ^ w_pop;
      r_count <= r_count
               + {1'b0, w_fetch}
               - {1'b0, w_pop};
    end
  end

  always_comb begin
    bus.imem_addr = r_pc;
    bus.imem_en   = w_fetch;
    bus.out_valid = w_valid;
    bus.out_pc    = w_valid ? r_q_pc[r_head]
                            : '0;
    bus.out_instr = w_valid ? r_q_instr[r_head]
                            : '0;
    fault         = (r_state == S_FAULT);
    busy          = (r_state == S_RUN);
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a
// randomized run against a queue-level reference model.
module tb_instruction_fetch;

  localparam int N = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_HALT = 2;
  localparam int M_FAULT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, halt, rv;
  logic [31:0] rpc;
  logic        fault, busy;
  logic [31:0] seed;

  logic        r4, s4, h4, rv4;
  logic [7:0]  rpc4;
  logic        fault4, busy4;

  instruction_fetch_if #(.n(N)) bus ();
  instruction_fetch_if #(.n(4)) bus4 ();

  instruction_fetch #(.n(N), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .halt(halt), .redirect_valid(rv),
    .redirect_pc(rpc), .fault(fault),
    .busy(busy), .bus(bus)
  );

  instruction_fetch #(.n(4), .RESET_PC(8'h0)) u_dut4 (
    .clk(clk), .reset(r4), .start(s4),
    .halt(h4), .redirect_valid(rv4),
    .redirect_pc(rpc4), .fault(fault4),
    .busy(busy4), .bus(bus4)
  );

  always_comb
    bus.imem_data = (bus.imem_addr * 32'h9E3779B1) ^ seed;
  always_comb
    bus4.imem_data = (bus4.imem_addr * 8'h3B) ^ seed[7:0];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [7:0] mem4(input logic [7:0] a);
    return (a * 8'h3B) ^ seed[7:0];
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int          mst;
  logic [31:0] mpc;
  ent_t        mq[$];

  logic        e_valid, e_en, e_fault, e_busy;
  logic [31:0] e_pc, e_ins, e_addr;

  int vecs = 0;
  int errs = 0;

  // drive one cycle, compute expected pre-edge outputs, advance model
  task automatic step(input logic rst_i, input logic st_i,
                      input logic h_i, input logic rv_i,
                      input logic [31:0] rpc_i,
                      input logic rdy_i);
    logic pop, inr, fetch;
    int   nst;
    @(negedge clk);
    reset = rst_i; start = st_i; halt = h_i;
    rv = rv_i; rpc = rpc_i; bus.out_ready = rdy_i;
    #1;
    pop   = (mq.size() > 0) && rdy_i;
    inr   = ({32'b0, mpc} < (64'd4 << N));
    fetch = (mst == M_RUN) && !h_i && !rv_i && inr
          && ((mq.size() < 2) || pop);
    e_valid = (mq.size() != 0);
    e_pc    = e_valid ? mq[0].pc : 32'h0;
    e_ins   = e_valid ? mq[0].ins : 32'h0;
    e_en    = fetch;
    e_addr  = mpc;
    e_fault = (mst == M_FAULT);
    e_busy  = (mst == M_RUN);
    if (rst_i) begin
      mst = M_IDLE; mpc = 32'h0; mq.delete();
    end else begin
      nst = mst;
      if (pop) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back('{pc: mpc, ins: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
      if (rv_i && mst != M_FAULT) begin
        mq.delete();
        if (rpc_i[1:0] != 2'b00) nst = M_FAULT;
        else begin
          mpc = rpc_i;
          if (mst == M_RUN && h_i) nst = M_HALT;
        end
      end else begin
        case (mst)
          M_IDLE: if (st_i) nst = h_i ? M_HALT : M_RUN;
          M_RUN: if (!inr) nst = M_FAULT;
                 else if (h_i) nst = M_HALT;
          M_HALT: if (st_i && !h_i) nst = M_RUN;
          default: nst = mst;
        endcase
      end
      mst = nst;
    end
  endtask

  task automatic step4(input logic rst_i, input logic st_i,
                       input logic rdy_i);
    @(negedge clk);
    r4 = rst_i; s4 = st_i; h4 = 1'b0; rv4 = 1'b0;
    rpc4 = 8'h0; bus4.out_ready = rdy_i;
    #1;
  endtask

  task automatic test_range;
    int fetches = 0;
    int seen40 = 0;
    logic [7:0] last_pc = 8'hFF;
    logic [7:0] last_ins = 8'h00;
    logic [7:0] exp_pc = 8'h00;
    step4(1'b1, 1'b0, 1'b1);
    step4(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 24; c++) begin
      step4(1'b0, 1'b0, 1'b1);
      if (bus4.imem_en) fetches++;
      if (bus4.out_valid) begin
        vecs++;
        if (bus4.out_pc !== exp_pc) begin
          errs++;
          $display("FAIL range_seq got=%h exp=%h",
                   bus4.out_pc, exp_pc);
        end
        last_pc = bus4.out_pc;
        last_ins = bus4.out_instr;
        exp_pc = exp_pc + 8'd4;
      end
      if (seen40 == 1) begin
        vecs++;
        if (fault4 !== 1'b1 || busy4 !== 1'b0) begin
          errs++;
          $display("FAIL range_fault got=%b exp=1", fault4);
        end
        seen40 = 2;
      end
      if (bus4.imem_addr == 8'h40 && seen40 == 0) begin
        vecs++;
        if (bus4.imem_en !== 1'b0 || fault4 !== 1'b0) begin
          errs++;
          $display("FAIL range_nofetch en=%b fault=%b exp=0/0",
                   bus4.imem_en, fault4);
        end
        seen40 = 1;
      end
    end
    vecs++;
    if (fetches != 16) begin
      errs++;
      $display("FAIL range_count got=%0d exp=16", fetches);
    end
    vecs++;
    if (last_pc !== 8'h3C || last_ins !== mem4(8'h3C)) begin
      errs++;
      $display("FAIL range_last got=%h/%h exp=3c/%h",
               last_pc, last_ins, mem4(8'h3C));
    end
    vecs++;
    if (seen40 != 2 || fault4 !== 1'b1) begin
      errs++;
      $display("FAIL range_sticky got=%0d/%b exp=2/1",
               seen40, fault4);
    end
  endtask

  task automatic test_reset;
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    vecs++;
    if ({bus.out_valid, bus.imem_en, fault, busy} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.out_valid, bus.imem_en, fault, busy});
    end
    vecs++;
    if (bus.imem_addr !== 32'h0 || bus.out_pc !== 32'h0
        || bus.out_instr !== 32'h0) begin
      errs++;
      $display("FAIL reset_values got=%h/%h/%h exp=0",
               bus.imem_addr, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_seq;
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    for (int c = 0; c < 6; c++) begin
      step(0, 0, 0, 0, 0, 1);
      vecs++;
      if (bus.imem_en !== 1'b1 || bus.imem_addr !== 32'(4 * c)) begin
        errs++;
        $display("FAIL seq_fetch got=%b/%h exp=1/%h",
                 bus.imem_en, bus.imem_addr, 32'(4 * c));
      end
      vecs++;
      if (c == 0) begin
        if (bus.out_valid !== 1'b0) begin
          errs++;
          $display("FAIL seq_latency got=%b exp=0", bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1
                   || bus.out_pc !== 32'(4 * (c - 1))
                   || bus.out_instr !== mem_word(32'(4 * (c - 1)))) begin
        errs++;
        $display("FAIL seq_out got=%h/%h exp=%h/%h",
                 bus.out_pc, bus.out_instr, 32'(4 * (c - 1)),
                 mem_word(32'(4 * (c - 1))));
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] h_pc, h_ins, x_pc;
    int pushes = 0;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0, 0);
      if (c == 0) begin h_pc = bus.out_pc; h_ins = bus.out_instr; end
      if (bus.imem_en) pushes++;
      vecs++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== h_pc
          || bus.out_instr !== h_ins) begin
        errs++;
        $display("FAIL stall_hold got=%h/%h exp=%h/%h",
                 bus.out_pc, bus.out_instr, h_pc, h_ins);
      end
    end
    vecs++;
    if (pushes != 1) begin
      errs++;
      $display("FAIL stall_pushes got=%0d exp=1", pushes);
    end
    x_pc = h_pc;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0, 1);
      vecs++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== x_pc
          || bus.out_instr !== mem_word(x_pc)
          || bus.imem_en !== 1'b1) begin
        errs++;
        $display("FAIL stall_drain got=%h en=%b exp=%h en=1",
                 bus.out_pc, bus.imem_en, x_pc);
      end
      x_pc = x_pc + 32'd4;
    end
  endtask

  task automatic test_redirect;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h10, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    vecs++;
    if (bus.out_pc !== 32'h10 || bus.imem_en !== 1'b0) begin
      errs++;
      $display("FAIL redir_full got=%h en=%b exp=10 en=0",
               bus.out_pc, bus.imem_en);
    end
    step(0, 0, 0, 1, 32'h40, 0);
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.imem_en !== 1'b1
        || bus.imem_addr !== 32'h40) begin
      errs++;
      $display("FAIL redir_flush got=%b/%b/%h exp=0/1/40",
               bus.out_valid, bus.imem_en, bus.imem_addr);
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 1);
      vecs++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(64 + 4 * c)) begin
        errs++;
        $display("FAIL redir_target got=%h exp=%h",
                 bus.out_pc, 32'(64 + 4 * c));
      end
    end
  endtask

  task automatic test_misalign;
    logic [31:0] a_pc;
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'h42, 0);
    a_pc = bus.imem_addr;
    vecs++;
    if (bus.imem_en !== 1'b0) begin
      errs++;
      $display("FAIL mis_nofetch got=%b exp=0", bus.imem_en);
    end
    for (int c = 0; c < 4; c++) begin
      step(0, 1, 0, (c == 2), 32'h80, 1);
      vecs++;
      if (fault !== 1'b1 || busy !== 1'b0 || bus.imem_en !== 1'b0
          || bus.out_valid !== 1'b0 || bus.imem_addr !== a_pc) begin
        errs++;
        $display("FAIL mis_fault got=%b%b%b%b pc=%h exp=1000 pc=%h",
                 fault, busy, bus.imem_en, bus.out_valid,
                 bus.imem_addr, a_pc);
      end
    end
    step(1, 1, 1, 1, 32'h80, 1);
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (fault !== 1'b0 || busy !== 1'b0 || bus.imem_addr !== 32'h0) begin
      errs++;
      $display("FAIL mis_reset got=%b%b/%h exp=00/0",
               fault, busy, bus.imem_addr);
    end
  endtask

  task automatic test_halt;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 1);
      vecs++;
      if (busy !== 1'b0 || bus.imem_en !== 1'b0
          || bus.out_valid !== (c < 2)
          || (c < 2 && bus.out_pc !== 32'(4 * c))) begin
        errs++;
        $display("FAIL halt_drain got=%b%b%b/%h exp=00%b/%h",
                 busy, bus.imem_en, bus.out_valid, bus.out_pc,
                 (c < 2), 32'(4 * c));
      end
    end
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (busy !== 1'b1 || bus.imem_en !== 1'b1
        || bus.imem_addr !== 32'h8) begin
      errs++;
      $display("FAIL halt_resume got=%b%b/%h exp=11/8",
               busy, bus.imem_en, bus.imem_addr);
    end
  endtask

  task automatic test_random;
    logic        r_rst, r_st, r_h, r_rv, r_rdy;
    logic [31:0] r_pc;
    step(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 1500; c++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_h   = ($urandom_range(0, 9) == 0);
      r_rv  = ($urandom_range(0, 11) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: r_pc = 32'($urandom_range(0, 255)) * 4 + 32'd2;
        1: r_pc = 32'h40000 - 32'($urandom_range(1, 3)) * 4;
        2: r_pc = 32'h40000;
        default: r_pc = 32'($urandom_range(0, 255)) * 4;
      endcase
      step(r_rst, r_st, r_h, r_rv, r_pc, r_rdy);
      vecs++;
      if (bus.out_valid !== e_valid || bus.out_pc !== e_pc
          || bus.out_instr !== e_ins) begin
        errs++;
        $display("FAIL rnd_out c=%0d got=%b/%h/%h exp=%b/%h/%h",
                 c, bus.out_valid, bus.out_pc, bus.out_instr,
                 e_valid, e_pc, e_ins);
      end
      vecs++;
      if (bus.imem_en !== e_en || bus.imem_addr !== e_addr) begin
        errs++;
        $display("FAIL rnd_imem c=%0d got=%b/%h exp=%b/%h",
                 c, bus.imem_en, bus.imem_addr, e_en, e_addr);
      end
      vecs++;
      if (fault !== e_fault || busy !== e_busy) begin
        errs++;
        $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b",
                 c, fault, busy, e_fault, e_busy);
      end
    end
  endtask

  initial begin
    seed = $urandom;
    reset = 1'b1; start = 1'b0; halt = 1'b0;
    rv = 1'b0; rpc = 32'h0; bus.out_ready = 1'b0;
    r4 = 1'b1; s4 = 1'b0; h4 = 1'b0;
    rv4 = 1'b0; rpc4 = 8'h0; bus4.out_ready = 1'b0;
    mst = M_IDLE; mpc = 32'h0;
    test_range;
    test_reset;
    test_seq;
    test_stall;
    test_redirect;
    test_misalign;
    test_halt;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
